pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode constants and stall-FSM encoding for the pipeline hazard controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_ERR      = 2'b10
   } stall_state_t;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;

   // Instructions whose rt field is a source operand rather than a destination.
   function automatic logic readsRt(input logic [5:0] op);
      return (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating data-memory wait counter; clr loads 1 (the first wait cycle), expired flags MEM_TIMEOUT.
import pipe_ctrl_pkg::*;

module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

   logic [CW-1:0] r_count;

   // Saturates at LIMIT so the counter can never wrap back to a small value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= CW'(1);
      end else if (inc && (r_count != LIMIT)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign expired = (r_count == LIMIT);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, branch/jump flush, data-memory freeze.
// Define DMEM_WAIT_EN to enable the memory-wait freeze, timeout counter and ERR state.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] id_opcode,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       ex_branch_taken,
   input  logic       mem_access,
   input  logic       dmem_ready,
   output logic       pc_we,
   output logic       ifid_we,
   output logic       idex_we,
   output logic       exmem_we,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic       memwb_bubble,
   output logic [1:0] stall_state,
   output logic       mem_timeout_err
);

   stall_state_t r_state;
   stall_state_t w_nextState;
   logic         r_ldValid;
   logic [4:0]   r_ldRt;
   logic         w_loadUse;
   logic         w_memStall;
   logic         w_timerClr;
   logic         w_timerInc;
   logic         w_expired;

`ifdef DMEM_WAIT_EN
   logic r_memErr;

   assign w_memStall = mem_access && !dmem_ready;

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_timerClr),
      .inc    (w_timerInc),
      .expired(w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_memErr <= 1'b0;
      end else if (w_nextState == ST_ERR) begin
         r_memErr <= 1'b1;
      end
   end

   assign mem_timeout_err = r_memErr;
`else
   logic w_unusedMem;

   assign w_memStall      = 1'b0;
   assign w_expired       = 1'b0;
   assign mem_timeout_err = 1'b0;
   assign w_unusedMem     = ^{mem_access, dmem_ready, w_timerClr, w_timerInc};
`endif

   assign w_loadUse = r_ldValid && (r_ldRt != 5'd0) &&
                      ((r_ldRt == id_rs) || ((r_ldRt == id_rt) && readsRt(id_opcode)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Tracks whether the instruction now entering EX is a load, for next-cycle load-use detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ldValid <= 1'b0;
         r_ldRt    <= 5'd0;
      end else if (idex_we) begin
         r_ldValid <= (id_opcode == OP_LW) && !idex_flush;
         r_ldRt    <= id_rt;
      end
   end

   // Priority: memory freeze, then taken branch, then load-use, then jump.
   always_comb begin
      w_nextState  = r_state;
      w_timerClr   = 1'b0;
      w_timerInc   = 1'b0;
      pc_we        = 1'b1;
      ifid_we      = 1'b1;
      idex_we      = 1'b1;
      exmem_we     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;

      if (r_state == ST_ERR) begin
         pc_we    = 1'b0;
         ifid_we  = 1'b0;
         idex_we  = 1'b0;
         exmem_we = 1'b0;
      end else if (w_memStall) begin
         pc_we        = 1'b0;
         ifid_we      = 1'b0;
         idex_we      = 1'b0;
         exmem_we     = 1'b0;
         memwb_bubble = 1'b1;
         if (r_state == ST_RUN) begin
            w_nextState = ST_MEM_WAIT;
            w_timerClr  = 1'b1;
         end else if (w_expired) begin
            w_nextState = ST_ERR;
         end else begin
            w_timerInc = 1'b1;
         end
      end else begin
         w_nextState = ST_RUN;
         if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (w_loadUse) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
         end else if (id_opcode == OP_J) begin
            ifid_flush = 1'b1;
         end
      end
   end

   assign stall_state = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; memory-wait expectations follow DMEM_WAIT_EN.
module tb_pipe_hazard_ctrl;

   localparam logic [5:0] OP_R  = 6'b000000;
   localparam logic [5:0] OP_J  = 6'b000010;
   localparam logic [5:0] OP_LW = 6'b100011;
   localparam logic [5:0] OP_SW = 6'b101011;

   // {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_bubble}
   localparam logic [6:0] C_NORM  = 7'b1111_000;
   localparam logic [6:0] C_STALL = 7'b0011_010;
   localparam logic [6:0] C_BR    = 7'b1111_110;
   localparam logic [6:0] C_JMP   = 7'b1111_100;
   localparam logic [6:0] C_FRZ   = 7'b0000_001;
   localparam logic [6:0] C_ERR   = 7'b0000_000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] idOpcode = OP_R;
   logic [4:0] idRs = 5'd0;
   logic [4:0] idRt = 5'd0;
   logic       exBranchTaken = 1'b0;
   logic       memAccess = 1'b0;
   logic       dmemReady = 1'b1;
   logic       pcWe, ifidWe, idexWe, exmemWe;
   logic       ifidFlush, idexFlush, memwbBubble;
   logic [1:0] stallState;
   logic       memTimeoutErr;

   logic [9:0] expQ[$];
   string      nameQ[$];
   int         total = 0;
   int         bad = 0;

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT(4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .id_opcode      (idOpcode),
      .id_rs          (idRs),
      .id_rt          (idRt),
      .ex_branch_taken(exBranchTaken),
      .mem_access     (memAccess),
      .dmem_ready     (dmemReady),
      .pc_we          (pcWe),
      .ifid_we        (ifidWe),
      .idex_we        (idexWe),
      .exmem_we       (exmemWe),
      .ifid_flush     (ifidFlush),
      .idex_flush     (idexFlush),
      .memwb_bubble   (memwbBubble),
      .stall_state    (stallState),
      .mem_timeout_err(memTimeoutErr)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] mk(input logic [6:0] ctl, input logic [1:0] st, input logic err);
      return {ctl, st, err};
   endfunction

   // One cycle of stimulus: drive just after the rising edge and queue the expected response.
   task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic br, input logic macc, input logic rdy,
                                input logic [9:0] exp, input string name);
      @(posedge clk);
      #1;
      rst           = 1'b0;
      idOpcode      = op;
      idRs          = rs;
      idRt          = rt;
      exBranchTaken = br;
      memAccess     = macc;
      dmemReady     = rdy;
      expQ.push_back(exp);
      nameQ.push_back(name);
   endtask

   task automatic idle(input logic [9:0] exp, input string name);
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, exp, name);
   endtask

   task automatic pulseReset();
      @(posedge clk);
      #1;
      rst           = 1'b1;
      idOpcode      = OP_R;
      idRs          = 5'd0;
      idRt          = 5'd0;
      exBranchTaken = 1'b0;
      memAccess     = 1'b0;
      dmemReady     = 1'b1;
   endtask

   task automatic checkOutput(input logic [9:0] exp, input string name);
      logic [9:0] got;
      got = {pcWe, ifidWe, idexWe, exmemWe, ifidFlush, idexFlush, memwbBubble,
             stallState, memTimeoutErr};
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%b expected=%b (pc ifid idex exmem iff idf bub st err)",
                  name, got, exp);
      end
   endtask

   // Monitor: consumes one queued expectation per cycle, mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkOutput(expQ.pop_front(), nameQ.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired got=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      pulseReset();
      idle(mk(C_NORM, 2'b00, 1'b0), "reset_idle");

      // Load-use on rs: exactly one stall cycle.
      applyStimulus(OP_LW, 5'd1, 5'd5, 1'b0, 1'b0, 1'b1, mk(C_NORM, 2'b00, 1'b0), "lw_r5");
      applyStimulus(OP_R, 5'd5, 5'd2, 1'b0, 1'b0, 1'b1, mk(C_STALL, 2'b00, 1'b0), "ldu_stall");
      applyStimulus(OP_R, 5'd5, 5'd2, 1'b0, 1'b0, 1'b1, mk(C_NORM, 2'b00, 1'b0), "ldu_release");
      applyStimulus(OP_R, 5'd3, 5'd4, 1'b0, 1'b0, 1'b1, mk(C_NORM, 2'b00, 1'b0), "ldu_after");

      // Load to r0 never stalls.
      applyStimulus(OP_LW, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, mk(C_NORM, 2'b00, 1'b0), "lw_r0");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, mk(C_NORM, 2'b00, 1'b0), "lw_r0_nostall");

      // rt match stalls for SW but not for a following LW.
      applyStimulus(OP_LW, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1, mk(C_NORM, 2'b00, 1'b0), "lw_r7");
      applyStimulus(OP_SW, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1, mk(C_STALL, 2'b00, 1'b0), "sw_rt_stall");
      applyStimulus(OP_SW, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1, mk(C_NORM, 2'b00, 1'b0), "sw_rt_release");
      applyStimulus(OP_LW, 5'd1, 5'd8, 1'b0, 1'b0, 1'b1, mk(C_NORM, 2'b00, 1'b0), "lw_r8");
      applyStimulus(OP_LW, 5'd1, 5'd8, 1'b0, 1'b0, 1'b1, mk(C_NORM, 2'b00, 1'b0), "lw_rt_nostall");
      idle(mk(C_NORM, 2'b00, 1'b0), "idle_after_lw");

      // Taken branch overrides a simultaneous load-use.
      applyStimulus(OP_LW, 5'd1, 5'd6, 1'b0, 1'b0, 1'b1, mk(C_NORM, 2'b00, 1'b0), "lw_r6");
      applyStimulus(OP_R, 5'd6, 5'd2, 1'b1, 1'b0, 1'b1, mk(C_BR, 2'b00, 1'b0), "br_over_ldu");
      applyStimulus(OP_R, 5'd6, 5'd2, 1'b0, 1'b0, 1'b1, mk(C_NORM, 2'b00, 1'b0), "br_no_stall");

      // Jump flushes IF/ID for one cycle only.
      applyStimulus(OP_J, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, mk(C_JMP, 2'b00, 1'b0), "jump");
      idle(mk(C_NORM, 2'b00, 1'b0), "jump_one_cycle");

`ifdef DMEM_WAIT_EN
      // Three not-ready cycles, then release.
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_FRZ, 2'b00, 1'b0), "frz_c1");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, mk(C_FRZ, 2'b01, 1'b0), "frz_c2_br");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_FRZ, 2'b01, 1'b0), "frz_c3");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, mk(C_NORM, 2'b01, 1'b0), "frz_release");
      idle(mk(C_NORM, 2'b00, 1'b0), "frz_back_run");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, mk(C_NORM, 2'b00, 1'b0), "mem_ready_nofrz");

      // Reset in the middle of a wait.
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_FRZ, 2'b00, 1'b0), "mid_c1");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_FRZ, 2'b01, 1'b0), "mid_c2");
      pulseReset();
      idle(mk(C_NORM, 2'b00, 1'b0), "mid_reset");

      // Timeout with MEM_TIMEOUT=4: four wait cycles, then sticky ERR until reset.
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_FRZ, 2'b00, 1'b0), "to_c1");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_FRZ, 2'b01, 1'b0), "to_w1");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_FRZ, 2'b01, 1'b0), "to_w2");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_FRZ, 2'b01, 1'b0), "to_w3");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_FRZ, 2'b01, 1'b0), "to_w4");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_ERR, 2'b10, 1'b1), "to_err");
      applyStimulus(OP_J, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, mk(C_ERR, 2'b10, 1'b1), "err_sticky");
      pulseReset();
      idle(mk(C_NORM, 2'b00, 1'b0), "err_reset");
`else
      // Without the wait feature dmem_ready is ignored: no freeze, no ERR.
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_NORM, 2'b00, 1'b0), "nofrz_c1");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, mk(C_BR, 2'b00, 1'b0), "nofrz_c2_br");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_NORM, 2'b00, 1'b0), "nofrz_c3");
      applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, mk(C_NORM, 2'b00, 1'b0), "nofrz_ready");
      applyStimulus(OP_LW, 5'd1, 5'd9, 1'b0, 1'b1, 1'b0, mk(C_NORM, 2'b00, 1'b0), "nofrz_lw_r9");
      applyStimulus(OP_R, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_STALL, 2'b00, 1'b0), "nofrz_ldu");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, mk(C_NORM, 2'b00, 1'b0), "noerr_wait");
      end
      applyStimulus(OP_J, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, mk(C_JMP, 2'b00, 1'b0), "noerr_jump");
      pulseReset();
      idle(mk(C_NORM, 2'b00, 1'b0), "noerr_reset");
`endif

      for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
         @(posedge clk);
      end
      if (expQ.size() > 0) begin
         bad++;
         $display("[TB] FAIL drain got=%0d pending expected=0 pending", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
